eth_rx_crc_check: RTL and testbench
===================================

# eth_rx_crc_check

Receive-side frame check for the 10-bit Ethernet byte stream `{cke, frm, dat[7:0]}` produced by the GMII/MII receiver.

- Verifies the 4-byte FCS (IEEE 802.3 CRC-32) and strips it from the frame.
- Checks frame length against configurable bounds.
- Emits one status pulse per frame.
- Is the receive counterpart of the transmit-side CRC inserter. It sits between the MAC receiver output and the packet parser.

## Interface
Parameters:
- `MIN_LEN`, 64 — minimum legal frame length in bytes, FCS included.
- `MAX_LEN`, 1522 — maximum legal frame length in bytes, FCS included.

Ports:
- `CLK` in 1 — stream clock (125 MHz). This is the single clock; there is no other.
- `RST_L` in 1 — synchronous, active-low reset.
- `IN_ETH_STREAM` in 10 — bit 9 = cke (byte strobe), bit 8 = frm (in-frame), bits 7:0 = data. The frame starts at the destination MAC and ends with the FCS; preamble and SFD are already removed.
- `OUT_ETH_STREAM` out 10 — same format, with the FCS removed.
- `FRM_OK` out 1 — single-cycle pulse: frame passed all checks.
- `FRM_BAD` out 1 — single-cycle pulse: CRC error, runt, oversize, or fewer than 5 bytes.
- `FRM_LEN` out 11 — received byte count, FCS included. Saturates at 2047. Valid with the pulse and held until the next pulse.

## Operation
- Inputs are sampled only on cycles with cke=1. Cycles with cke=0 change no state.
- State `IDLE`:
  - cke & frm → load the first byte and go to `IN_FRAME`.
  - CRC register is initialised to 0xFFFFFFFF.
  - Length counter starts at 1.
- State `IN_FRAME`:
  - cke & frm → process the byte:
    - Update the CRC with the reflected polynomial 0xEDB88320, LSB first.
    - Increment the length counter, saturating at 2047.
    - Shift the byte into a 4-entry delay line.
  - cke & !frm → end of frame:
    - Evaluate the checks, pulse the status, and return to `IDLE`.
    - The delay-line contents (the FCS) are discarded, never emitted.
- Output bytes:
  - A byte is emitted only when a new byte pushes a full delay line. The emitted byte is the oldest entry, with out frm=1.
  - Before the line holds 4 bytes, out frm=0 on those cke cycles.
- Good-CRC criterion: the CRC register after all bytes, FCS included, equals the residue 0xDEBB20E3.
- Outcome at end of frame:
  - FRM_OK = residue match & len ≥ MIN_LEN & len ≤ MAX_LEN.
  - FRM_BAD = the complement of FRM_OK, with exactly one of the two asserted.
- Frames shorter than 5 bytes:
  - No out frm=1 bytes are emitted.
  - FRM_BAD is forced, regardless of the CRC result.
- Consecutive frames: a new frame may start on the cke immediately after the terminating cke. The delay line and CRC register are reinitialised by the start condition.
- Reset, including mid-frame:
  - All outputs are 0 (FRM_LEN = 0).
  - State returns to `IDLE`; the delay line and counter are cleared.
  - No status pulse is emitted for the aborted frame.

## Timing
- Latency: 1 cycle. OUT cke is IN cke registered, so the input byte cadence (every cycle for GE, every 10th cycle for FE) is preserved exactly.
- Payload offset: output byte n corresponds to input byte n, but appears 4 cke-strobes later in the stream.
- The status pulse is asserted in the same cycle as the OUT cke that carries the end-of-frame frm=0.
- The FRM_LEN update coincides with the pulse.
- Reset state of every output is 0.

## Structure
- Package `eth_stream_pkg` holds:
  - stream bit indices (CKE=9, FRM=8, DAT=7:0);
  - CRC constants: polynomial 0xEDB88320, init 0xFFFFFFFF, residue 0xDEBB20E3;
  - defaults for MIN_LEN and MAX_LEN.
- Sub-module `eth_crc32_d8`: combinational next-CRC function for one byte (32-bit state, 8-bit data). It is shared with the transmit-side CRC block.
- The top level contains the FSM, the delay line, the length counter, and the status registers.

## Test plan
- Good frame, GE cadence: 64-byte frame (60 payload bytes + correct FCS), cke every cycle → exactly 60 out bytes, identical to the payload; FRM_OK=1; FRM_LEN=64.
- CRC error: same frame with bit 0 of byte 20 flipped → 60 out bytes; FRM_BAD=1; FRM_OK=0; FRM_LEN=64.
- Runt: 20-byte frame with valid FCS → 16 out bytes; FRM_BAD=1; FRM_LEN=20.
- Tiny frame: 3-byte frame → 0 out frm=1 bytes; FRM_BAD=1; FRM_LEN=3.
- FE cadence and back-to-back frames: cke every 10th cycle; two 64-byte good frames separated by a single frm=0 cke → two FRM_OK pulses; 120 total out bytes; out cke spacing is still 10 cycles.
- Reset mid-frame: RST_L low for 1 cycle after byte 30 → outputs 0, no status pulse; the next 64-byte good frame yields FRM_OK and LEN=64.

Source files
------------

// File: rtl/eth_stream_pkg.sv
// eth_stream_pkg
// Shared definitions for the 10-bit receive/transmit Ethernet byte stream
// {cke, frm, dat[7:0]}. It holds:
//   - the stream bit positions;
//   - the IEEE 802.3 CRC-32 constants (reflected form);
//   - the default legal frame-length bounds;
//   - the receive checker state encoding;
//   - the bitwise CRC helper used by the one-byte CRC block.
package eth_stream_pkg;

  // Stream bit positions
  localparam int CKE_BIT = 9;
  localparam int FRM_BIT = 8;
  localparam int DAT_MSB = 7;
  localparam int DAT_LSB = 0;

  // CRC-32, reflected polynomial, processed LSB first.
  // The residue is the register value after the FCS itself has been run
  // through the CRC, with no final inversion.
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  // Frame length bounds in bytes, FCS included
  localparam int MIN_LEN_DEF = 64;
  localparam int MAX_LEN_DEF = 1522;

  // Length counter width and its saturation value
  localparam logic [10:0] LEN_SAT = 11'd2047;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } rx_state_e;

  // One data bit into the reflected CRC register
  function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic b);
    logic [31:0] r;
    if ((crc[0] ^ b) == 1'b1) begin
      r = {1'b0, crc[31:1]} ^ CRC_POLY;
    end else begin
      r = {1'b0, crc[31:1]};
    end
    return r;
  endfunction

  // One byte into the CRC register, bit 0 of the byte first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] r;
    r = crc;
    for (int i = 0; i < 8; i++) begin
      r = crc32_bit(r, d[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8
// Combinational next-state function of the IEEE 802.3 CRC-32 for one byte.
// This block is shared by the receive checker and the transmit CRC inserter.
// Ports:
//   crc_i [31:0] : current CRC register
//   dat_i [7:0]  : data byte (bit 0 enters first)
//   crc_o [31:0] : CRC register after the byte
module eth_crc32_d8
  import eth_stream_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  dat_i,
  output logic [31:0] crc_o
);

  // Byte-wide CRC update
  always_comb begin
    crc_o = crc32_byte(crc_i, dat_i);
  end

endmodule

// File: rtl/eth_rx_crc_check.sv
// eth_rx_crc_check
// Receive-side frame check. It sits between the MAC receiver and the packet
// parser. It performs these functions:
//   - checks the FCS (CRC-32) of each frame;
//   - strips the 4 FCS bytes by holding the stream in a 4-byte delay line;
//   - checks the frame length against MIN_LEN..MAX_LEN;
//   - reports one OK/BAD pulse per frame.
// Parameters:
//   MIN_LEN, MAX_LEN : legal frame length bounds in bytes, FCS included
// Ports:
//   CLK             : stream clock
//   RST_L           : synchronous active-low reset
//   IN_ETH_STREAM   : {cke, frm, dat[7:0]}, frame from DA through FCS
//   OUT_ETH_STREAM  : same format, FCS removed, one cycle behind IN cke
//   FRM_OK / FRM_BAD: one-cycle status pulse at end of frame
//   FRM_LEN         : byte count (FCS included, saturating), held to next pulse
module eth_rx_crc_check
  import eth_stream_pkg::*;
#(
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic        CLK,
  input  logic        RST_L,
  input  logic [9:0]  IN_ETH_STREAM,
  output logic [9:0]  OUT_ETH_STREAM,
  output logic        FRM_OK,
  output logic        FRM_BAD,
  output logic [10:0] FRM_LEN
);

  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);

  logic        in_cke_s;
  logic        in_frm_s;
  logic [7:0]  in_dat_s;

  rx_state_e   state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_seed_s;
  logic [31:0] crc_next_s;
  logic [10:0] len_q, len_d;
  logic [10:0] len_inc_s;
  logic [31:0] dly_q, dly_d;      // [7:0] newest byte, [31:24] oldest byte
  logic [2:0]  fill_q, fill_d;    // bytes held in the delay line, 0..4
  logic [9:0]  out_q, out_d;
  logic        ok_q, ok_d;
  logic        bad_q, bad_d;
  logic [10:0] frm_len_q, frm_len_d;
  logic        frame_good_s;

  assign in_cke_s = IN_ETH_STREAM[CKE_BIT];
  assign in_frm_s = IN_ETH_STREAM[FRM_BIT];
  assign in_dat_s = IN_ETH_STREAM[DAT_MSB:DAT_LSB];

  // The first byte of a frame starts from the init value, so a new frame
  // never depends on whatever the previous frame left in crc_q.
  assign crc_seed_s = (state_q == ST_IDLE) ? CRC_INIT : crc_q;

  eth_crc32_d8 u_crc (
    .crc_i (crc_seed_s),
    .dat_i (in_dat_s),
    .crc_o (crc_next_s)
  );

  assign len_inc_s = (len_q == LEN_SAT) ? len_q : (len_q + 11'd1);

  // Frames under 5 bytes are bad even if MIN_LEN is set very low.
  assign frame_good_s = (crc_q == CRC_RESIDUE) &&
                        (len_q >= MIN_LEN_C) &&
                        (len_q <= MAX_LEN_C) &&
                        (len_q >= 11'd5);

  // Next-state, delay line, counters and status for one input cycle
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    dly_d     = dly_q;
    fill_d    = fill_q;
    out_d     = {in_cke_s, 1'b0, 8'd0};  // out cke always follows in cke
    ok_d      = 1'b0;
    bad_d     = 1'b0;
    frm_len_d = frm_len_q;

    if (in_cke_s) begin
      case (state_q)
        ST_IDLE: begin
          if (in_frm_s) begin
            state_d = ST_IN_FRAME;
            crc_d   = crc_next_s;
            len_d   = 11'd1;
            dly_d   = {24'd0, in_dat_s};
            fill_d  = 3'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_IN_FRAME: begin
          if (in_frm_s) begin
            crc_d = crc_next_s;
            len_d = len_inc_s;
            dly_d = {dly_q[23:0], in_dat_s};
            // Only a push into a full line releases a byte; the last four
            // bytes of the frame (the FCS) therefore never leave.
            if (fill_q == 3'd4) begin
              out_d  = {1'b1, 1'b1, dly_q[31:24]};
              fill_d = fill_q;
            end else begin
              fill_d = fill_q + 3'd1;
            end
          end else begin
            state_d   = ST_IDLE;
            ok_d      = frame_good_s;
            bad_d     = ~frame_good_s;
            frm_len_d = len_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      state_q   <= ST_IDLE;
      crc_q     <= CRC_INIT;
      len_q     <= 11'd0;
      dly_q     <= 32'd0;
      fill_q    <= 3'd0;
      out_q     <= 10'd0;
      ok_q      <= 1'b0;
      bad_q     <= 1'b0;
      frm_len_q <= 11'd0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      dly_q     <= dly_d;
      fill_q    <= fill_d;
      out_q     <= out_d;
      ok_q      <= ok_d;
      bad_q     <= bad_d;
      frm_len_q <= frm_len_d;
    end
  end

  assign OUT_ETH_STREAM = out_q;
  assign FRM_OK         = ok_q;
  assign FRM_BAD        = bad_q;
  assign FRM_LEN        = frm_len_q;

endmodule

// File: tb/tb_eth_rx_crc_check.sv
// tb_eth_rx_crc_check
// Randomized self-checking bench for eth_rx_crc_check.
// The reference model works at the frame level:
//   - each frame is a list of bytes;
//   - the FCS is the standard CRC-32 of the payload, sent LSB byte first;
//   - expected output is the payload, and the status follows from the length
//     rules and a direct comparison of the recomputed FCS with the sent one.
module tb_eth_rx_crc_check;

  localparam int MIN_L = 64;
  localparam int MAX_L = 1522;

  logic        CLK = 1'b0;
  logic        RST_L;
  logic [9:0]  IN_ETH_STREAM;
  logic [9:0]  OUT_ETH_STREAM;
  logic        FRM_OK;
  logic        FRM_BAD;
  logic [10:0] FRM_LEN;

  eth_rx_crc_check #(.MIN_LEN(MIN_L), .MAX_LEN(MAX_L)) dut (
    .CLK            (CLK),
    .RST_L          (RST_L),
    .IN_ETH_STREAM  (IN_ETH_STREAM),
    .OUT_ETH_STREAM (OUT_ETH_STREAM),
    .FRM_OK         (FRM_OK),
    .FRM_BAD        (FRM_BAD),
    .FRM_LEN        (FRM_LEN)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  int         exp_cnt_q[$];
  int         exp_len_q[$];
  bit         exp_ok_q[$];
  logic [7:0] exp_byte_q[$];
  logic [7:0] got_q[$];
  int         len_hold = 0;

  logic [9:0] last_in  = 10'd0;
  logic       last_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Standard CRC-32 (byte-xor form, final inversion) of the first n bytes
  function automatic logic [31:0] ref_crc32(input logic [7:0] m[$], input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, m[i]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // Input and reset value seen by the DUT at each rising edge
  always @(posedge CLK) begin
    last_in  <= IN_ETH_STREAM;
    last_rst <= RST_L;
  end

  // Output monitor: cadence, collected bytes, status against the model
  always @(negedge CLK) begin
    if (!last_rst) begin
      got_q.delete();
      len_hold = 0;
    end else begin
      chk("out_cke", 32'(OUT_ETH_STREAM[9]), 32'(last_in[9]));
      chk("frm_without_cke", 32'(OUT_ETH_STREAM[8] & ~OUT_ETH_STREAM[9]), 32'd0);
      if (OUT_ETH_STREAM[9] && OUT_ETH_STREAM[8]) got_q.push_back(OUT_ETH_STREAM[7:0]);
      if (FRM_OK || FRM_BAD) begin
        if (exp_cnt_q.size() == 0) begin
          chk("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          int  e_cnt;
          int  e_len;
          bit  e_ok;
          e_cnt = exp_cnt_q.pop_front();
          e_len = exp_len_q.pop_front();
          e_ok  = exp_ok_q.pop_front();
          chk("out_byte_count", 32'(got_q.size()), 32'(e_cnt));
          for (int i = 0; i < e_cnt; i++) begin
            logic [7:0] eb;
            eb = exp_byte_q.pop_front();
            if (i < got_q.size()) chk("out_data", 32'(got_q[i]), 32'(eb));
          end
          chk("frm_ok", 32'(FRM_OK), 32'(e_ok));
          chk("frm_bad", 32'(FRM_BAD), 32'(!e_ok));
          chk("frm_len", 32'(FRM_LEN), 32'(e_len));
          len_hold = e_len;
        end
        got_q.delete();
      end else begin
        chk("frm_len_hold", 32'(FRM_LEN), 32'(len_hold));
      end
    end
  end

  task automatic drive_byte(input logic f, input logic [7:0] b, input int cad);
    IN_ETH_STREAM = {1'b1, f, b};
    @(posedge CLK); #1;
    for (int j = 1; j < cad; j++) begin
      IN_ETH_STREAM = 10'd0;
      @(posedge CLK); #1;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out"}, 32'(OUT_ETH_STREAM), 32'd0);
    chk({tag, "_ok"},  32'(FRM_OK), 32'd0);
    chk({tag, "_bad"}, 32'(FRM_BAD), 32'd0);
    chk({tag, "_len"}, 32'(FRM_LEN), 32'd0);
  endtask

  // Build and send one frame; abort_after >= 0 applies a 1-cycle reset
  // after that many bytes instead of ending the frame normally.
  task automatic send_frame(input int len, input int flip_idx, input int cad, input int abort_after);
    logic [7:0]  fr[$];
    logic [31:0] fcs;
    int          n_out;
    bit          e_ok;
    if (len >= 4) begin
      for (int i = 0; i < len - 4; i++) fr.push_back(8'($urandom));
      fcs = ref_crc32(fr, len - 4);
      for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
    end else begin
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
    end
    if (flip_idx >= 0 && flip_idx < len) fr[flip_idx] = fr[flip_idx] ^ 8'h01;

    for (int i = 0; i < len; i++) begin
      if (i == abort_after) begin
        RST_L = 1'b0;
        IN_ETH_STREAM = 10'd0;
        @(posedge CLK); #1;
        check_zero_outputs("abort_rst");
        RST_L = 1'b1;
        return;
      end
      drive_byte(1'b1, fr[i], cad);
    end

    n_out = (len >= 5) ? len - 4 : 0;
    e_ok  = 1'b0;
    if (len >= 5 && len >= MIN_L && len <= MAX_L) begin
      e_ok = (ref_crc32(fr, len - 4) == {fr[len-1], fr[len-2], fr[len-3], fr[len-4]});
    end
    exp_cnt_q.push_back(n_out);
    exp_len_q.push_back((len > 2047) ? 2047 : len);
    exp_ok_q.push_back(e_ok);
    for (int i = 0; i < n_out; i++) exp_byte_q.push_back(fr[i]);
    drive_byte(1'b0, 8'd0, cad);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      IN_ETH_STREAM = ($urandom_range(0, 1) == 0) ? 10'h200 : 10'h000;
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    RST_L = 1'b0;
    IN_ETH_STREAM = 10'd0;
    repeat (3) @(posedge CLK);
    #1;
    check_zero_outputs("reset");
    RST_L = 1'b1;
    idle_gap(2);

    // Directed cases
    send_frame(64, -1, 1, -1);      // good frame, GE cadence
    idle_gap(3);
    send_frame(64, 20, 1, -1);      // CRC error in byte 20
    idle_gap(3);
    send_frame(20, -1, 1, -1);      // runt with valid FCS
    idle_gap(3);
    send_frame(3, -1, 1, -1);       // tiny frame
    idle_gap(3);
    send_frame(4, -1, 2, -1);       // four bytes: nothing emitted
    idle_gap(3);
    send_frame(64, -1, 10, -1);     // FE cadence, back-to-back
    send_frame(64, -1, 10, -1);
    idle_gap(3);
    send_frame(64, -1, 1, 30);      // reset mid-frame
    send_frame(64, -1, 1, -1);
    idle_gap(3);
    send_frame(1522, -1, 1, -1);    // largest legal
    send_frame(1523, -1, 1, -1);    // oversize
    idle_gap(2);
    send_frame(2100, -1, 1, -1);    // length counter saturation
    idle_gap(2);

    // Random frames
    for (int f = 0; f < 20; f++) begin
      int len;
      int cad;
      int flip;
      case ($urandom_range(0, 2))
        0:       len = $urandom_range(1, 10);
        1:       len = $urandom_range(55, 75);
        default: len = $urandom_range(1510, 1530);
      endcase
      cad  = (len < 100) ? $urandom_range(1, 3) : 1;
      flip = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      send_frame(len, flip, cad, -1);
      idle_gap($urandom_range(0, 3));
    end

    IN_ETH_STREAM = 10'd0;
    for (int i = 0; i < 100 && exp_cnt_q.size() != 0; i++) @(posedge CLK);
    @(negedge CLK);
    chk("pending_status", 32'(exp_cnt_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
